// File: rtl/alu_result_writeback.sv
// Writeback stage for the 64-bit ALU: holds one result in Z and returns it to the
// 32-bit bus in one or two handshaked beats, updating HI/LO, flags and a done counter.
module alu_result_writeback #(
   parameter logic [4:0]  OP_MUL = 5'b00010,
   parameter logic [4:0]  OP_DIV = 5'b00011,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [63:0]      alu_c,
   input  logic [4:0]       alu_op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      bus_out,
   output logic             bus_valid,
   output logic             bus_hi,
   input  logic             bus_ready,
   output logic [31:0]      hi_q,
   output logic [31:0]      lo_q,
   output logic             zero_flag,
   output logic             neg_flag,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BEAT_LO = 2'd1,
      BEAT_HI = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      z_q, z_d;
   logic [4:0]       op_q, op_d;
   logic [31:0]      hi_d, lo_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      bus_out_q, bus_out_d;
   logic             bus_valid_q, bus_valid_d;
   logic             bus_hi_q, bus_hi_d;
   logic             busy_q, busy_d;

   logic in_wide;
   logic in_mul;
   logic held_wide;

   assign in_mul    = (alu_op == OP_MUL);
   assign in_wide   = in_mul || (alu_op == OP_DIV);
   assign held_wide = (op_q == OP_MUL) || (op_q == OP_DIV);

   assign in_ready  = (state_q == IDLE) && !clear;
   assign bus_out   = bus_out_q;
   assign bus_valid = bus_valid_q;
   assign bus_hi    = bus_hi_q;
   assign zero_flag = zero_q;
   assign neg_flag  = neg_q;
   assign busy      = busy_q;
   assign ops_done  = cnt_q;

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               z_d     = alu_c;
               op_d    = alu_op;
               state_d = BEAT_LO;
               if (in_wide) begin
                  hi_d = alu_c[63:32];
                  lo_d = alu_c[31:0];
               end
               // Only a MUL product is judged on all 64 bits; DIV flags follow the quotient
               if (in_mul) begin
                  zero_d = (alu_c == 64'd0);
                  neg_d  = alu_c[63];
               end else begin
                  zero_d = (alu_c[31:0] == 32'd0);
                  neg_d  = alu_c[31];
               end
            end
         end
         BEAT_LO: begin
            if (bus_ready) begin
               if (held_wide) begin
                  state_d = BEAT_HI;
               end else begin
                  state_d = IDLE;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         BEAT_HI: begin
            if (bus_ready) begin
               state_d = IDLE;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are registered, so they are decoded from the next state and next Z
   always_comb begin
      bus_valid_d = (state_d != IDLE);
      bus_hi_d    = (state_d == BEAT_HI);
      busy_d      = (state_d != IDLE);
      bus_out_d   = '0;
      case (state_d)
         BEAT_LO: bus_out_d = z_d[31:0];
         BEAT_HI: bus_out_d = z_d[63:32];
         default: bus_out_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= IDLE;
         z_q         <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         bus_out_q   <= '0;
         bus_valid_q <= 1'b0;
         bus_hi_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
         op_q        <= op_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         cnt_q       <= cnt_d;
         bus_out_q   <= bus_out_d;
         bus_valid_q <= bus_valid_d;
         bus_hi_q    <= bus_hi_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: vector table plus hand-written stall,
// back-pressure, mid-operation clear and counter-wrap sequences.
module tb_alu_result_writeback;

   logic        clock = 1'b0;
   logic        clear;
   logic [63:0] alu_c;
   logic [4:0]  alu_op;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] bus_out;
   logic        bus_valid;
   logic        bus_hi;
   logic        bus_ready;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        zero_flag;
   logic        neg_flag;
   logic        busy;
   logic [15:0] ops_done;

   logic        clear2;
   logic        in_valid2;
   logic        w_in_ready;
   logic [31:0] w_bus_out;
   logic        w_bus_valid;
   logic        w_bus_hi;
   logic [31:0] w_hi_q;
   logic [31:0] w_lo_q;
   logic        w_zero;
   logic        w_neg;
   logic        w_busy;
   logic [1:0]  w_ops_done;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   alu_result_writeback #(.OP_MUL(5'b00010), .OP_DIV(5'b00011), .CNT_W(16)) dut (
      .clock(clock), .clear(clear), .alu_c(alu_c), .alu_op(alu_op),
      .in_valid(in_valid), .in_ready(in_ready), .bus_out(bus_out),
      .bus_valid(bus_valid), .bus_hi(bus_hi), .bus_ready(bus_ready),
      .hi_q(hi_q), .lo_q(lo_q), .zero_flag(zero_flag), .neg_flag(neg_flag),
      .busy(busy), .ops_done(ops_done)
   );

   alu_result_writeback #(.CNT_W(2)) dut_wrap (
      .clock(clock), .clear(clear2), .alu_c(64'h0000_0000_0000_0005),
      .alu_op(5'b00000), .in_valid(in_valid2), .in_ready(w_in_ready),
      .bus_out(w_bus_out), .bus_valid(w_bus_valid), .bus_hi(w_bus_hi),
      .bus_ready(1'b1), .hi_q(w_hi_q), .lo_q(w_lo_q), .zero_flag(w_zero),
      .neg_flag(w_neg), .busy(w_busy), .ops_done(w_ops_done)
   );

   typedef struct {
      logic [4:0]  op;
      logic [63:0] c;
      logic        wide;
      logic        zero;
      logic        neg;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   int exp_ops;
   int exp_w[5];

   initial begin
      // op, c, wide, zero, neg, expected HI, expected LO after capture
      vecs[0] = '{5'b00010, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1] = '{5'b00011, 64'h0000_0007_0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000};
      vecs[2] = '{5'b00000, 64'h1234_5678_0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000};
      vecs[3] = '{5'b00010, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{5'b00010, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000};
      vecs[5] = '{5'b00011, 64'h8000_0000_0000_0005, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0005};
      vecs[6] = '{5'b11111, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0005};
      vecs[7] = '{5'b00001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0005};
      exp_w = '{1, 2, 3, 0, 1};

      // Reset with in_valid held high: nothing may be captured
      clear = 1'b1; clear2 = 1'b1; in_valid2 = 1'b0;
      in_valid = 1'b1; alu_op = 5'b00010; alu_c = 64'hDEAD_BEEF_1234_5678; bus_ready = 1'b1;
      step(); step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_bus_out", bus_out, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_bus_hi", bus_hi, 0);
      chk("rst_hi", hi_q, 0);
      chk("rst_lo", lo_q, 0);
      chk("rst_flags", {zero_flag, neg_flag}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ops", ops_done, 0);
      clear = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      step();
      chk("post_rst_no_capture", busy, 0);

      exp_ops = 0;
      for (int i = 0; i < 8; i++) begin
         alu_op = vecs[i].op; alu_c = vecs[i].c; in_valid = 1'b1; bus_ready = 1'b1;
         chk($sformatf("v%0d_in_ready", i), in_ready, 1);
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_lo_valid", i), bus_valid, 1);
         chk($sformatf("v%0d_lo_hi", i), bus_hi, 0);
         chk($sformatf("v%0d_lo_word", i), bus_out, vecs[i].c[31:0]);
         chk($sformatf("v%0d_hi_q", i), hi_q, vecs[i].hi);
         chk($sformatf("v%0d_lo_q", i), lo_q, vecs[i].lo);
         chk($sformatf("v%0d_zero", i), zero_flag, vecs[i].zero);
         chk($sformatf("v%0d_neg", i), neg_flag, vecs[i].neg);
         chk($sformatf("v%0d_busy", i), busy, 1);
         if (vecs[i].wide) begin
            step();
            chk($sformatf("v%0d_hbeat_valid", i), bus_valid, 1);
            chk($sformatf("v%0d_hbeat_hi", i), bus_hi, 1);
            chk($sformatf("v%0d_hbeat_word", i), bus_out, vecs[i].c[63:32]);
         end
         step();
         exp_ops++;
         chk($sformatf("v%0d_end_valid", i), bus_valid, 0);
         chk($sformatf("v%0d_end_ready", i), in_ready, 1);
         chk($sformatf("v%0d_end_bus", i), bus_out, 0);
         chk($sformatf("v%0d_ops", i), ops_done, exp_ops);
      end

      // Narrow shift result held under a 3-cycle bus stall
      alu_op = 5'b00100; alu_c = 64'h0000_0000_8000_0000; in_valid = 1'b1; bus_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus_ready = 1'b1;
         chk($sformatf("stall%0d_valid", k), bus_valid, 1);
         chk($sformatf("stall%0d_word", k), bus_out, 32'h8000_0000);
         chk($sformatf("stall%0d_hi", k), bus_hi, 0);
         chk($sformatf("stall%0d_ops", k), ops_done, exp_ops);
         if (k < 3) step();
      end
      step();
      exp_ops++;
      chk("stall_end_valid", bus_valid, 0);
      chk("stall_ops", ops_done, exp_ops);
      chk("stall_hi_q", hi_q, 32'h8000_0000);
      chk("stall_lo_q", lo_q, 32'h0000_0005);
      chk("stall_neg", neg_flag, 1);

      // Upstream holds in_valid across a busy period with a changed payload
      alu_op = 5'b00000; alu_c = 64'h0000_0000_AAAA_0001; in_valid = 1'b1; bus_ready = 1'b0;
      step();
      alu_op = 5'b00001; alu_c = 64'h0000_0000_BBBB_0002;
      chk("bp_first_word", bus_out, 32'hAAAA_0001);
      chk("bp_in_ready_busy", in_ready, 0);
      step();
      chk("bp_held_word", bus_out, 32'hAAAA_0001);
      bus_ready = 1'b1;
      step();
      exp_ops++;
      chk("bp_idle_valid", bus_valid, 0);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_ops1", ops_done, exp_ops);
      step();
      in_valid = 1'b0;
      chk("bp_second_valid", bus_valid, 1);
      chk("bp_second_word", bus_out, 32'hBBBB_0002);
      step();
      exp_ops++;
      chk("bp_ops2", ops_done, exp_ops);

      // Clear while the upper beat of a MUL is on the bus
      alu_op = 5'b00010; alu_c = 64'h1111_2222_3333_4444; in_valid = 1'b1; bus_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mc_lo_word", bus_out, 32'h3333_4444);
      step();
      chk("mc_hi_beat", bus_hi, 1);
      chk("mc_hi_word", bus_out, 32'h1111_2222);
      clear = 1'b1;
      step();
      chk("mc_in_ready_clr", in_ready, 0);
      chk("mc_valid", bus_valid, 0);
      chk("mc_bus_out", bus_out, 0);
      chk("mc_hi_q", hi_q, 0);
      chk("mc_lo_q", lo_q, 0);
      chk("mc_ops", ops_done, 0);
      chk("mc_busy", busy, 0);
      clear = 1'b0;
      step();
      chk("mc_no_hbeat", bus_valid, 0);
      chk("mc_ops_after", ops_done, 0);

      // Two-bit counter wraps after the fourth delivery
      clear2 = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         in_valid2 = 1'b1;
         step();
         in_valid2 = 1'b0;
         chk($sformatf("wrap%0d_word", i), w_bus_out, 32'h0000_0005);
         step();
         chk($sformatf("wrap%0d_ops", i), w_ops_done, exp_w[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
